// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types for the load/store unit BRAM port.
//   lsu_size_e  : access size encoding carried on req_size
//   lsu_state_e : state encoding of the lsu_bram_port FSM (also on dbg_state)
// Helpers:
//   lsu_eff_lo     : byte offset with the bits below the access size cleared
//   lsu_misaligned : true when the offset is not a multiple of the size
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_RESP    = 2'b10
    } lsu_state_e;

    function automatic logic [1:0] lsu_eff_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the LSU BRAM port.
// Store side (live request):
//   st_size, st_lo   : access size and effective byte offset
//   st_wdata         : right-justified store data
//   st_we_mask       : per-lane write enables
//   st_data          : store data replicated across all lanes
// Load side (held request):
//   ld_size, ld_lo   : access size and effective byte offset
//   ld_unsigned      : zero-extend when 1, sign-extend when 0
//   ld_rdata         : raw BRAM word
//   ld_data          : lane-selected, extended result
// ---------------------------------------------------------------------------
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_we_mask,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Replicating the data means the BRAM lane mapping needs no shifter on
    // the write side; the lane enables pick the copy that lands.
    always_comb begin
        st_we_mask = 4'b0000;
        st_data    = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_we_mask = 4'b0001 << st_lo;
                st_data    = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_we_mask = st_lo[1] ? 4'b1100 : 4'b0011;
                st_data    = {2{st_wdata[15:0]}};
            end
            SZ_WORD: begin
                st_we_mask = 4'b1111;
                st_data    = st_wdata;
            end
            default: begin
                st_we_mask = 4'b0000;
                st_data    = st_wdata;
            end
        endcase
    end

    // Move the addressed lane(s) down to bit 0, then extend.
    assign ld_shifted = ld_rdata >> {ld_lo, 3'b000};

    always_comb begin
        ld_data = 32'h0;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                           : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                           : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_WORD: ld_data = ld_rdata;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_bram_port.sv
// ---------------------------------------------------------------------------
// lsu_bram_port
// Connects a single-outstanding load/store request stream to one port of a
// byte-enable BRAM with a 1-cycle registered read.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid must not depend on ready, and once raised the
// response (rsp_valid, rsp_err, rsp_rdata) holds until it is consumed.
//
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata, rsp_err            : load data (0 for stores/errors), error
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata : BRAM port
//   dbg_state                     : current FSM state (lsu_state_e)
//
// Build option: define LSU_MISALIGN_CHK_EN to turn misaligned half/word
// accesses into error responses; otherwise the low offset bits are cleared
// and the access goes ahead.
// ---------------------------------------------------------------------------
module lsu_bram_port
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsigned,
    input  logic [ADDR_WIDTH+1:0]       req_addr,
    input  logic [NB_COL*COL_WIDTH-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [NB_COL*COL_WIDTH-1:0] rsp_rdata,
    output logic                        rsp_err,
    output logic                        mem_en,
    output logic [NB_COL-1:0]           mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [NB_COL*COL_WIDTH-1:0] mem_wdata,
    input  logic [NB_COL*COL_WIDTH-1:0] mem_rdata,
    output logic [1:0]                  dbg_state
);

    lsu_state_e  state;
    logic [1:0]  ld_size_q;
    logic [1:0]  ld_lo_q;
    logic        ld_uns_q;

    logic        accept;
    logic        req_err;
    logic [1:0]  eff_lo;
    logic [3:0]  st_we_mask;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && (state == ST_IDLE);
    assign eff_lo    = lsu_eff_lo(req_size, req_addr[1:0]);
    assign dbg_state = state;

`ifdef LSU_MISALIGN_CHK_EN
    assign req_err = (req_size == SZ_RSVD) || lsu_misaligned(req_size, req_addr[1:0]);
`else
    assign req_err = (req_size == SZ_RSVD);
`endif

    lsu_align u_align (
        .st_size     (req_size),
        .st_lo       (eff_lo),
        .st_wdata    (req_wdata),
        .st_we_mask  (st_we_mask),
        .st_data     (st_data),
        .ld_size     (ld_size_q),
        .ld_lo       (ld_lo_q),
        .ld_unsigned (ld_uns_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    // BRAM is driven straight from the request in the acceptance cycle so
    // the read data arrives while the FSM sits in RD_WAIT.
    assign mem_en    = accept && !req_err;
    assign mem_we    = (accept && !req_err && req_we) ? st_we_mask : '0;
    assign mem_addr  = req_addr[ADDR_WIDTH+1:2];
    assign mem_wdata = st_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            ld_size_q <= SZ_BYTE;
            ld_lo_q   <= 2'b00;
            ld_uns_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            // Keep what lane selection needs; the request
                            // inputs are free to change after acceptance.
                            state     <= ST_RD_WAIT;
                            ld_size_q <= req_size;
                            ld_lo_q   <= eff_lo;
                            ld_uns_q  <= req_unsigned;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ld_data;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule
